// File: rtl/fp_to_bfp_conv.sv
// Float vector to block-floating-point converter: unpack, max-exponent tree, align (ROUND_NEAREST_EN selects RNE rounding).
// Latency $clog2(P)+2 cycles, one vector per cycle.
// No backpressure: valid-only pipeline, outputs hold between valid cycles.
module fp_to_bfp_conv #(
    parameter int P    = 8,
    parameter int BIT  = 32,
    parameter int FPM  = 23,
    parameter int BFPM = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [P-1:0][BIT-1:0]    in_floats,
    output logic                     out_valid,
    output logic [P-1:0][BFPM:0]     out_mants,
    output logic [P-1:0]             out_signs,
    output logic [BIT-FPM-2:0]       out_exp,
    output logic                     out_special,
    output logic [15:0]              out_count
);
    localparam int EXP = BIT - FPM - 1;
    localparam int LOG = $clog2(P);
`ifdef ROUND_NEAREST_EN
    localparam int MW = FPM + 1;
`else
    // Truncation only ever looks at the top BFPM+1 mantissa bits.
    localparam int MW = BFPM + 1;
`endif

    logic [LOG:0]      vld_q;
    logic [P-1:0]      sign_q [LOG+1];
    logic [P-1:0]      spec_q [LOG+1];
    logic [EXP-1:0]    exp_q  [LOG+1][P];
    logic [EXP-1:0]    emax_q [LOG+1][P];
    logic [MW-1:0]     mant_q [LOG+1][P];

    logic [P-1:0]      sign_d;
    logic [P-1:0]      spec_d;
    logic [EXP-1:0]    exp_d  [P];
    logic [MW-1:0]     mant_d [P];
    logic [BFPM:0]     mant_f [P];
    logic [EXP-1:0]    sh;

    logic              out_valid_q;
    logic [P-1:0][BFPM:0] out_mants_q;
    logic [P-1:0]      out_signs_q;
    logic [EXP-1:0]    out_exp_q;
    logic              out_special_q;
    logic [15:0]       out_count_q;

    function automatic logic [EXP-1:0] emax2(input logic [EXP-1:0] a, input logic [EXP-1:0] b);
        return (a > b) ? a : b;
    endfunction

    always_comb begin
        for (int i = 0; i < P; i++) begin
            sign_d[i] = in_floats[i][BIT-1];
            spec_d[i] = &in_floats[i][BIT-2:FPM];
            exp_d[i]  = in_floats[i][BIT-2:FPM];
            mant_d[i] = {1'b1, in_floats[i][FPM-1 -: MW-1]};
            if (exp_d[i] == '0)
                mant_d[i] = '0;
            if (spec_d[i])
                mant_d[i] = '1;
        end
    end

`ifndef ROUND_NEAREST_EN
    logic unused_frac;
    always_comb begin
        unused_frac = 1'b0;
        for (int i = 0; i < P; i++)
            unused_frac = unused_frac ^ (^in_floats[i][FPM-BFPM-1:0]);
    end
`endif

    // Data path carries no reset; only the valid chain is cleared.
    always_ff @(posedge clk) begin
        sign_q[0] <= sign_d;
        spec_q[0] <= spec_d;
        for (int i = 0; i < P; i++) begin
            exp_q[0][i]  <= exp_d[i];
            emax_q[0][i] <= exp_d[i];
            mant_q[0][i] <= mant_d[i];
        end
        for (int l = 1; l <= LOG; l++) begin
            sign_q[l] <= sign_q[l-1];
            spec_q[l] <= spec_q[l-1];
            for (int i = 0; i < P; i++) begin
                exp_q[l][i]  <= exp_q[l-1][i];
                mant_q[l][i] <= mant_q[l-1][i];
                // Butterfly pairing leaves every lane holding the vector max.
                emax_q[l][i] <= emax2(emax_q[l-1][i], emax_q[l-1][i ^ (1 << (l-1))]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            vld_q <= '0;
        else
            vld_q <= {vld_q[LOG-1:0], in_valid};
    end

`ifdef ROUND_NEAREST_EN
    logic [EXP-1:0]   shc;
    logic [2*MW-1:0]  ext;
    logic             rnd;
`endif

    always_comb begin
        sh = '0;
`ifdef ROUND_NEAREST_EN
        shc = '0;
        ext = '0;
        rnd = 1'b0;
`endif
        for (int i = 0; i < P; i++) begin
            sh = emax_q[LOG][i] - exp_q[LOG][i];
`ifdef ROUND_NEAREST_EN
            shc = (sh > EXP'(MW)) ? EXP'(MW) : sh;
            ext = {mant_q[LOG][i], {MW{1'b0}}} >> shc;
            mant_f[i] = ext[2*MW-1 -: BFPM+1];
            rnd = ext[2*MW-BFPM-2] & ((|ext[2*MW-BFPM-3:0]) | mant_f[i][0]);
            if (rnd)
                mant_f[i] = (&mant_f[i]) ? mant_f[i] : mant_f[i] + 1'b1;
`else
            mant_f[i] = mant_q[LOG][i] >> sh;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            out_mants_q   <= '0;
            out_signs_q   <= '0;
            out_exp_q     <= '0;
            out_special_q <= 1'b0;
            out_count_q   <= '0;
        end else begin
            out_valid_q <= vld_q[LOG];
            if (vld_q[LOG]) begin
                for (int i = 0; i < P; i++)
                    out_mants_q[i] <= mant_f[i];
                out_signs_q   <= sign_q[LOG];
                out_exp_q     <= emax_q[LOG][0];
                out_special_q <= |spec_q[LOG];
                out_count_q   <= out_count_q + 16'd1;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_mants   = out_mants_q;
    assign out_signs   = out_signs_q;
    assign out_exp     = out_exp_q;
    assign out_special = out_special_q;
    assign out_count   = out_count_q;

endmodule

// File: tb/tb_fp_to_bfp_conv.sv
// Directed bench for fp_to_bfp_conv with P=8, BFPM=4.
module tb_fp_to_bfp_conv;
    localparam int P = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic [P-1:0][31:0]   in_floats;
    logic                 out_valid;
    logic [P-1:0][4:0]    out_mants;
    logic [P-1:0]         out_signs;
    logic [7:0]           out_exp;
    logic                 out_special;
    logic [15:0]          out_count;

    int n_run  = 0;
    int n_fail = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    fp_to_bfp_conv #(.P(P), .BIT(32), .FPM(23), .BFPM(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_floats   (in_floats),
        .out_valid   (out_valid),
        .out_mants   (out_mants),
        .out_signs   (out_signs),
        .out_exp     (out_exp),
        .out_special (out_special),
        .out_count   (out_count)
    );

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive one vector, then expect a single-cycle output pulse exactly 5 cycles later.
    task automatic run_vec(input string tag, input logic [P-1:0][31:0] v,
                           input logic [P-1:0][4:0] em, input logic [P-1:0] es,
                           input logic [7:0] ee, input logic esp);
        int lat;
        lat = 0;
        @(negedge clk);
        in_floats = v;
        in_valid  = 1'b1;
        for (int c = 1; c <= 12 && lat == 0; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) lat = c;
        end
        exp_cnt++;
        check({tag, ".lat"},   lat, 5);
        check({tag, ".mants"}, out_mants, em);
        check({tag, ".signs"}, out_signs, es);
        check({tag, ".exp"},   out_exp, ee);
        check({tag, ".spec"},  out_special, esp);
        check({tag, ".count"}, out_count, exp_cnt);
        @(negedge clk);
        check({tag, ".pulse"}, out_valid, 1'b0);
    endtask

    function automatic logic [P-1:0][31:0] stream_vec(input int j);
        logic [P-1:0][31:0] v;
        for (int k = 0; k < P - 1; k++)
            v[k] = {1'b0, 8'(127 - k), 23'd0};
        v[0] = {1'b0, 8'd127, 4'(j % 16), 19'd0};
        v[7] = {1'b0, 8'd117, 23'd0};
        return v;
    endfunction

    function automatic logic [P-1:0][4:0] stream_exp(input int j);
        logic [P-1:0][4:0] em;
        logic [4:0] one;
        one = 5'b10000;
        for (int k = 1; k < P - 1; k++)
            em[k] = one >> k;
        em[0] = {1'b1, 4'(j % 16)};
        em[7] = 5'b00000;
        return em;
    endfunction

    logic [P-1:0][31:0] v;
    logic [P-1:0][4:0]  em;
    int got, first, last, base;
    logic saw_vld;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_floats = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle_vld", out_valid, 1'b0);
            check("idle_dat", {out_count, out_exp, out_signs, out_special, out_mants}, '0);
        end

        for (int k = 0; k < P; k++) begin v[k] = 32'h3F800000; em[k] = 5'b01000; end
        v[0] = 32'h40000000; em[0] = 5'b10000;
        run_vec("aligned", v, em, 8'h00, 8'd128, 1'b0);

        for (int k = 0; k < P; k++) begin v[k] = 32'h0; em[k] = 5'b00000; end
        v[3] = 32'hBFC00000; em[3] = 5'b11000;
        run_vec("signzero", v, em, 8'b00001000, 8'd127, 1'b0);

        for (int k = 0; k < P; k++) begin v[k] = 32'h3F800000; em[k] = 5'b10000; end
        v[0] = 32'h3F8C0000;
`ifdef ROUND_NEAREST_EN
        em[0] = 5'b10010;
`else
        em[0] = 5'b10001;
`endif
        run_vec("round", v, em, 8'h00, 8'd127, 1'b0);

        v[0] = 32'h3FFC0000; em[0] = 5'b11111;
        run_vec("satur", v, em, 8'h00, 8'd127, 1'b0);

        got = 0; first = -1; last = -1; base = exp_cnt;
        fork
            begin
                for (int j = 0; j < 20; j++) begin
                    @(negedge clk);
                    in_valid  = 1'b1;
                    in_floats = stream_vec(j);
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        if (first < 0) first = c;
                        last = c;
                        check("stream.mants", out_mants, stream_exp(got));
                        check("stream.exp", out_exp, 8'd127);
                        check("stream.count", out_count, base + got + 1);
                        got++;
                    end
                end
            end
        join
        exp_cnt = base + 20;
        check("stream.n", got, 20);
        check("stream.contig", last - first, 19);
        check("stream.total", out_count, exp_cnt);

        for (int k = 0; k < P; k++) begin v[k] = 32'h3F800000; em[k] = 5'b00000; end
        v[5] = 32'h7F800000; em[5] = 5'b11111;
        run_vec("special", v, em, 8'h00, 8'd255, 1'b1);

        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_floats = stream_vec(j);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        saw_vld  = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid) saw_vld = 1'b1;
        end
        check("flush.vld", saw_vld, 1'b0);
        check("flush.count", out_count, 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
